uart_imem_loader: RTL and testbench

- Parametrised successor to the fixed 32-bit UART instruction loader in the wrapper.
- Takes bytes from the UART receiver and packs them little-endian into DATA_W-bit words. Writes the words to instruction memory at incrementing addresses.
- Ends the load after END_COUNT consecutive END_WORD words. Adds inter-byte timeout, BREAK abort, overflow detection and a written-word count.

---
 rtl/uart_loader_pkg.sv | 28 ++
 rtl/uart_word_assembler.sv | 79 +++++++
 rtl/uart_imem_loader.sv | 170 +++++++++++++++++
 tb/tb_uart_imem_loader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
// Holds the loader FSM encoding and small width helpers used by the top
// level and by the word assembler.
package uart_loader_pkg;

  // FSM encoding kept as plain constants so older tools and waveform
  // viewers that expect raw 2-bit codes keep working.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_WRITE   = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  localparam int BYTE_W = 8;

  // Number of byte lanes in a memory word (LANES = DATA_W/8).
  function automatic int lanes_for(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Bits needed to hold any value in 0..max_val; never less than one bit so
  // degenerate configurations (single lane, timeout disabled) still elaborate.
  function automatic int width_for(input int max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Packs received UART bytes little-endian into DATA_W-bit words.
//
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   en            - loader is accepting bytes (COLLECT or WRITE); when low
//                   any partial word is dropped
//   discard       - drop the partial word this cycle (BREAK); wins over rx_valid
//   rx_valid      - one-cycle strobe, rx_data holds a received byte
//   rx_data       - received byte
//   word_valid    - combinational strobe: this cycle's byte completes a word
//   word          - the completed word, valid together with word_valid
//   timeout_hit   - combinational strobe: partial word dropped by inter-byte
//                   timeout this cycle
module uart_word_assembler
  import uart_loader_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              discard,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              word_valid,
  output logic [DATA_W-1:0] word,
  output logic              timeout_hit
);

  localparam int LANES = lanes_for(DATA_W);
  localparam int LW    = width_for(LANES - 1);
  localparam int TW    = width_for(TIMEOUT_CYC);

  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYC);

  logic [LW-1:0]     lane;
  logic [DATA_W-1:0] shift_q;
  logic [TW-1:0]     idle_cnt;

  assign word_valid = en && !discard && rx_valid && (lane == LANE_LAST);

  // A byte arriving in the same cycle as the limit counts as activity, so the
  // timeout only fires on a genuinely idle cycle.
  assign timeout_hit = (TIMEOUT_CYC > 0) && en && !discard && !rx_valid &&
                       (lane != '0) && (idle_cnt == TO_LIM);

  // The completed word merges the final byte combinationally, so the loader
  // can latch it on the same edge that captures the last byte.
  always_comb begin
    word = shift_q;
    word[BYTE_W*lane +: BYTE_W] = rx_data;
  end

  // Lane counter, byte insert register and inter-byte idle counter. Lanes are
  // only ever filled in order from 0, so stale upper bytes from an abandoned
  // word are always overwritten before a word completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane     <= '0;
      shift_q  <= '0;
      idle_cnt <= '0;
    end else if (!en || discard) begin
      lane     <= '0;
      idle_cnt <= '0;
    end else if (rx_valid) begin
      shift_q[BYTE_W*lane +: BYTE_W] <= rx_data;
      lane     <= (lane == LANE_LAST) ? '0 : lane + 1'b1;
      idle_cnt <= '0;
    end else if (timeout_hit) begin
      lane     <= '0;
      idle_cnt <= '0;
    end else if ((lane != '0) && (idle_cnt != TO_LIM)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// UART instruction-memory loader: assembles received bytes into DATA_W-bit
// words and writes them to consecutive memory addresses until END_COUNT
// consecutive END_WORD sentinels have been written.
//
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   arm           - level; 1 enables a load, 0 returns to IDLE
//   rx_valid      - one-cycle strobe, rx_data holds a received byte
//   rx_data       - received byte
//   rx_break      - one-cycle strobe, BREAK seen on the line
//   mem_we        - memory write enable (one-cycle pulse)
//   mem_addr      - memory write address
//   mem_wdata     - memory write data
//   busy          - high in COLLECT or WRITE
//   write_done    - level; the load terminated (sentinels or overflow)
//   word_count    - words written during this load
//   err_overflow  - sticky; a word arrived while memory was full
//   err_timeout   - sticky; a partial word was dropped by timeout
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter int              DEPTH       = 64,
  parameter int              ADDR_W      = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] END_WORD  = {DATA_W{1'b1}},
  parameter int              END_COUNT   = 2,
  parameter int              TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_break,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic              err_timeout
);

  localparam int RUN_W = width_for(END_COUNT);

  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(END_COUNT);

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [RUN_W-1:0]  run;
  logic [RUN_W-1:0]  run_next;
  logic [DATA_W-1:0] word_q;
  logic              full;

  logic              asm_en;
  logic              asm_discard;
  logic              word_valid;
  logic [DATA_W-1:0] word_asm;
  logic              timeout_hit;

  // Bytes are accepted in WRITE too, so a byte landing in the write cycle
  // becomes lane 0 of the next word instead of being lost.
  assign asm_en      = arm && ((state == ST_COLLECT) || (state == ST_WRITE));
  assign asm_discard = rx_break && (state == ST_COLLECT);

  uart_word_assembler #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_assembler (
    .clk         (clk),
    .rst         (rst),
    .en          (asm_en),
    .discard     (asm_discard),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .word_valid  (word_valid),
    .word        (word_asm),
    .timeout_hit (timeout_hit)
  );

  // wr_ptr is one bit wider than the address, so "full" is exact and it
  // doubles as the saturating written-word count.
  assign full       = (wr_ptr == DEPTH_V);
  assign run_next   = (word_q == END_WORD) ? run + 1'b1 : '0;

  // Address and data are gated with the strobe so the memory bus stays quiet
  // outside write cycles.
  assign mem_we     = (state == ST_WRITE) && !full;
  assign mem_addr   = mem_we ? wr_ptr[ADDR_W-1:0] : '0;
  assign mem_wdata  = mem_we ? word_q : '0;
  assign busy       = (state == ST_COLLECT) || (state == ST_WRITE);
  assign word_count = wr_ptr;

  // Loader FSM, write pointer, sentinel run and sticky status flags. Status
  // survives a disarm so software can read it back, and clears only when a
  // new load starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      wr_ptr       <= '0;
      run          <= '0;
      word_q       <= '0;
      write_done   <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state        <= ST_COLLECT;
            wr_ptr       <= '0;
            run          <= '0;
            write_done   <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
          end
        end

        ST_COLLECT: begin
          if (!arm) begin
            state <= ST_IDLE;
          end else begin
            if (rx_break || timeout_hit) begin
              run <= '0;
            end
            if (timeout_hit) begin
              err_timeout <= 1'b1;
            end
            if (word_valid) begin
              word_q <= word_asm;
              state  <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          if (!full) begin
            wr_ptr <= wr_ptr + 1'b1;
            run    <= run_next;
          end else begin
            err_overflow <= 1'b1;
          end

          // With single-byte words a byte in the write cycle completes the
          // next word immediately, hence the WRITE-to-WRITE path.
          if (!arm) begin
            state <= ST_IDLE;
          end else if (full || (run_next == RUN_LIM)) begin
            state      <= ST_DONE;
            write_done <= 1'b1;
          end else if (word_valid) begin
            word_q <= word_asm;
            state  <= ST_WRITE;
          end else begin
            state <= ST_COLLECT;
          end
        end

        default: begin
          if (!arm) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader.
// Two instances share the byte stream: dut_a (DEPTH=64, TIMEOUT_CYC=100)
// and dut_b (DEPTH=4, no timeout); each is armed separately so only one
// loads at a time. Expected memory writes are queued by the stimulus and
// popped by per-instance monitors on the falling edge.
module tb_uart_imem_loader;

  logic        clk;
  logic        rst;
  logic        arm_a;
  logic        arm_b;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_break;

  logic        a_we;
  logic [5:0]  a_addr;
  logic [31:0] a_wdata;
  logic        a_busy;
  logic        a_done;
  logic [6:0]  a_wc;
  logic        a_ovf;
  logic        a_tmo;

  logic        b_we;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic        b_busy;
  logic        b_done;
  logic [2:0]  b_wc;
  logic        b_ovf;
  logic        b_tmo;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  int cyc      = 0;
  int tests    = 0;
  int failures = 0;

  uart_imem_loader #(
    .DATA_W      (32),
    .DEPTH       (64),
    .END_COUNT   (2),
    .TIMEOUT_CYC (100)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm_a),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_break     (rx_break),
    .mem_we       (a_we),
    .mem_addr     (a_addr),
    .mem_wdata    (a_wdata),
    .busy         (a_busy),
    .write_done   (a_done),
    .word_count   (a_wc),
    .err_overflow (a_ovf),
    .err_timeout  (a_tmo)
  );

  uart_imem_loader #(
    .DATA_W      (32),
    .DEPTH       (4),
    .END_COUNT   (2),
    .TIMEOUT_CYC (0)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm_b),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_break     (rx_break),
    .mem_we       (b_we),
    .mem_addr     (b_addr),
    .mem_wdata    (b_wdata),
    .busy         (b_busy),
    .write_done   (b_done),
    .word_count   (b_wc),
    .err_overflow (b_ovf),
    .err_timeout  (b_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitors: every mem_we must match the head of the queue, in the
  // exact cycle after the word's last byte.
  always @(negedge clk) begin
    if (!rst && a_we) begin
      tests++;
      if (qa.size() == 0) begin
        failures++;
        $display("[TB] FAIL write_a_unexpected: got addr=%0h data=%h at cyc %0d, none expected", a_addr, a_wdata, cyc);
      end else begin
        ea = qa.pop_front();
        if ((a_addr != ea.addr[5:0]) || (a_wdata != ea.data) || (cyc != ea.cyc)) begin
          failures++;
          $display("[TB] FAIL write_a: got addr=%0h data=%h cyc=%0d, expected addr=%0h data=%h cyc=%0d",
                   a_addr, a_wdata, cyc, ea.addr, ea.data, ea.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_we) begin
      tests++;
      if (qb.size() == 0) begin
        failures++;
        $display("[TB] FAIL write_b_unexpected: got addr=%0h data=%h at cyc %0d, none expected", b_addr, b_wdata, cyc);
      end else begin
        eb = qb.pop_front();
        if ((b_addr != eb.addr[1:0]) || (b_wdata != eb.data) || (cyc != eb.cyc)) begin
          failures++;
          $display("[TB] FAIL write_b: got addr=%0h data=%h cyc=%0d, expected addr=%0h data=%h cyc=%0d",
                   b_addr, b_wdata, cyc, eb.addr, eb.data, eb.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    tick();
    rx_valid = 1'b0;
    rx_break = 1'b0;
    repeat (n - 1) tick();
  endtask

  task automatic driveByte(input logic [7:0] b);
    tick();
    rx_valid = 1'b1;
    rx_data  = b;
    rx_break = 1'b0;
  endtask

  task automatic driveBreak(input logic with_byte, input logic [7:0] b);
    tick();
    rx_valid = with_byte;
    rx_data  = b;
    rx_break = 1'b1;
  endtask

  // Sends one word LSB first, back to back; when a write is expected it is
  // due in the cycle after the final byte.
  task automatic applyStimulus(input logic [31:0] w, input bit exp_wr, input int addr, input bit to_b);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      driveByte(w[8*i +: 8]);
      if (i == 3 && exp_wr) begin
        e.cyc  = cyc + 1;
        e.addr = addr;
        e.data = w;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    arm_a    = 1'b0;
    arm_b    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_break = 1'b0;

    // Reset state
    repeat (2) tick();
    checkOutput("rst_we",   {63'd0, a_we},   64'd0);
    checkOutput("rst_addr", {58'd0, a_addr}, 64'd0);
    checkOutput("rst_data", {32'd0, a_wdata}, 64'd0);
    checkOutput("rst_busy", {63'd0, a_busy}, 64'd0);
    checkOutput("rst_done", {63'd0, a_done}, 64'd0);
    checkOutput("rst_wc",   {57'd0, a_wc},   64'd0);
    checkOutput("rst_ovf",  {63'd0, a_ovf},  64'd0);
    checkOutput("rst_tmo",  {63'd0, a_tmo},  64'd0);
    rst = 1'b0;
    tick();

    // Two words, little-endian, back to back
    arm_a = 1'b1;
    tick();
    checkOutput("arm_busy", {63'd0, a_busy}, 64'd1);
    applyStimulus(32'hFC010113, 1'b1, 0, 1'b0);
    applyStimulus(32'h02812E23, 1'b1, 1, 1'b0);
    quiet(3);
    checkOutput("t1_wc",   {57'd0, a_wc},   64'd2);
    checkOutput("t1_done", {63'd0, a_done}, 64'd0);

    // Three data words then two sentinels end the load
    arm_a = 1'b0;
    tick();
    arm_a = 1'b1;
    tick();
    checkOutput("t2_wc_clear", {57'd0, a_wc}, 64'd0);
    applyStimulus(32'h00000013, 1'b1, 0, 1'b0);
    applyStimulus(32'h00100093, 1'b1, 1, 1'b0);
    applyStimulus(32'h00208113, 1'b1, 2, 1'b0);
    applyStimulus(32'hFFFFFFFF, 1'b1, 3, 1'b0);
    applyStimulus(32'hFFFFFFFF, 1'b1, 4, 1'b0);
    quiet(3);
    checkOutput("t2_done", {63'd0, a_done}, 64'd1);
    checkOutput("t2_busy", {63'd0, a_busy}, 64'd0);
    checkOutput("t2_wc",   {57'd0, a_wc},   64'd5);
    applyStimulus(32'h12345678, 1'b0, 0, 1'b0);
    quiet(3);
    checkOutput("t2_wc_after_done", {57'd0, a_wc}, 64'd5);

    // Status survives disarm; a non-sentinel resets the run
    arm_a = 1'b0;
    tick();
    checkOutput("t3_done_held", {63'd0, a_done}, 64'd1);
    checkOutput("t3_wc_held",   {57'd0, a_wc},   64'd5);
    arm_a = 1'b1;
    tick();
    tick();
    checkOutput("t3_done_clear", {63'd0, a_done}, 64'd0);
    applyStimulus(32'hFFFFFFFF, 1'b1, 0, 1'b0);
    applyStimulus(32'h00000013, 1'b1, 1, 1'b0);
    applyStimulus(32'hFFFFFFFF, 1'b1, 2, 1'b0);
    quiet(3);
    checkOutput("t3_done_run_reset", {63'd0, a_done}, 64'd0);
    applyStimulus(32'hFFFFFFFF, 1'b1, 3, 1'b0);
    quiet(3);
    checkOutput("t3_done", {63'd0, a_done}, 64'd1);
    checkOutput("t3_wc",   {57'd0, a_wc},   64'd4);

    // Inter-byte timeout drops a partial word
    arm_a = 1'b0;
    tick();
    arm_a = 1'b1;
    tick();
    driveByte(8'h11);
    driveByte(8'h22);
    quiet(150);
    checkOutput("t4_tmo",  {63'd0, a_tmo},  64'd1);
    checkOutput("t4_wc",   {57'd0, a_wc},   64'd0);
    checkOutput("t4_busy", {63'd0, a_busy}, 64'd1);
    applyStimulus(32'hAABBCCDD, 1'b1, 0, 1'b0);
    quiet(3);
    checkOutput("t4_wc_after", {57'd0, a_wc}, 64'd1);

    // BREAK drops the partial word and clears the sentinel run
    applyStimulus(32'hFFFFFFFF, 1'b1, 1, 1'b0);
    driveByte(8'hFF);
    driveByte(8'hFF);
    driveBreak(1'b0, 8'h00);
    quiet(2);
    applyStimulus(32'hFFFFFFFF, 1'b1, 2, 1'b0);
    quiet(3);
    checkOutput("t5_done_after_break", {63'd0, a_done}, 64'd0);
    driveByte(8'h55);
    driveBreak(1'b1, 8'h66);
    quiet(2);
    applyStimulus(32'h01020304, 1'b1, 3, 1'b0);
    quiet(3);
    checkOutput("t5_wc",  {57'd0, a_wc},  64'd4);
    checkOutput("t5_tmo", {63'd0, a_tmo}, 64'd1);

    // Disarm mid-word discards it; the next load starts clean
    driveByte(8'h77);
    driveByte(8'h88);
    quiet(1);
    arm_a = 1'b0;
    tick();
    arm_a = 1'b1;
    tick();
    tick();
    checkOutput("t6_wc_clear",  {57'd0, a_wc},  64'd0);
    checkOutput("t6_tmo_clear", {63'd0, a_tmo}, 64'd0);
    applyStimulus(32'h0BADF00D, 1'b1, 0, 1'b0);
    quiet(3);
    checkOutput("t6_wc", {57'd0, a_wc}, 64'd1);

    // Overflow on the small instance
    arm_a = 1'b0;
    tick();
    arm_b = 1'b1;
    tick();
    applyStimulus(32'h11111111, 1'b1, 0, 1'b1);
    applyStimulus(32'h22222222, 1'b1, 1, 1'b1);
    applyStimulus(32'h33333333, 1'b1, 2, 1'b1);
    applyStimulus(32'h44444444, 1'b1, 3, 1'b1);
    applyStimulus(32'h55555555, 1'b0, 0, 1'b1);
    quiet(3);
    checkOutput("ovf_flag", {63'd0, b_ovf}, 64'd1);
    checkOutput("ovf_done", {63'd0, b_done}, 64'd1);
    checkOutput("ovf_wc",   {61'd0, b_wc},   64'd4);
    checkOutput("ovf_busy", {63'd0, b_busy}, 64'd0);
    arm_b = 1'b0;
    quiet(2);
    checkOutput("queue_a_empty", 64'(qa.size()), 64'd0);
    checkOutput("queue_b_empty", 64'(qb.size()), 64'd0);

    // Reset during a WRITE cycle clears outputs without a clock edge
    arm_a = 1'b1;
    tick();
    tick();
    driveByte(8'h01);
    driveByte(8'h02);
    driveByte(8'h03);
    driveByte(8'h04);
    tick();
    rx_valid = 1'b0;
    checkOutput("rstw_we_before", {63'd0, a_we}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstw_we",   {63'd0, a_we},    64'd0);
    checkOutput("rstw_addr", {58'd0, a_addr},  64'd0);
    checkOutput("rstw_data", {32'd0, a_wdata}, 64'd0);
    checkOutput("rstw_busy", {63'd0, a_busy},  64'd0);
    checkOutput("rstw_wc",   {57'd0, a_wc},    64'd0);
    checkOutput("rstw_done", {63'd0, a_done},  64'd0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
